// File: rtl/pc_flag_unit.sv
// pc_flag_unit: program counter and branch resolution behind the 8-bit ALU.
// Holds the compare flags and a loadable branch-target table.
// Owns the run/halt sequencing for program execution.
//
// state | meaning
// IDLE  | out of reset; waiting for start
// RUN   | executing; pc advances or branches each unstalled cycle
// DONE  | halted; pc holds the halt address until start
module pc_flag_unit #(
    parameter int PC_WIDTH  = 10,
    parameter int LUT_DEPTH = 16,
    localparam int IDX_W    = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                halt,
    input  logic                alu_equal,
    input  logic                alu_lessThan,
    input  logic                flagWrite,
    input  logic [1:0]          branchType,
    input  logic [IDX_W-1:0]    branchIdx,
    input  logic                lutWrite,
    input  logic [IDX_W-1:0]    lutWrAddr,
    input  logic [PC_WIDTH-1:0] lutWrData,
    output logic [PC_WIDTH-1:0] pc,
    output logic                flagEq,
    output logic                flagLt,
    output logic                taken,
    output logic                running,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_LT   = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    state_t              state;
    logic [PC_WIDTH-1:0] lut [LUT_DEPTH];
    logic                branchCond;
    logic                execute;

    // An instruction only executes in RUN on an unstalled cycle.
    assign execute = (state == RUN) && !stall && !reset;

    // Branch decision against the stored (old) flags; halt and stall suppress it.
    always_comb begin
        branchCond = 1'b0;
        unique case (branchType)
            BR_NONE: branchCond = 1'b0;
            BR_EQ:   branchCond = flagEq;
            BR_LT:   branchCond = flagLt;
            BR_JMP:  branchCond = 1'b1;
            default: branchCond = 1'b0;
        endcase
        taken = execute && !halt && branchCond;
    end

    // Sequencer, pc, flags and target table; table reads see the pre-edge contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            flagEq  <= 1'b0;
            flagLt  <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else begin
            if (lutWrite) begin
                lut[lutWrAddr] <= lutWrData;
            end

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= '0;
                        running <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (flagWrite) begin
                            flagEq <= alu_equal;
                            flagLt <= alu_lessThan;
                        end
                        if (halt) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (taken) begin
                            pc <= lut[branchIdx];
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_flag_unit.sv
// Directed bench for pc_flag_unit: expected register state is queued as each
// cycle's stimulus is driven and compared after the clock edge.
module tb_pc_flag_unit;

    localparam int PW = 10;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset, start, stall, halt;
    logic          alu_equal, alu_lessThan, flagWrite;
    logic [1:0]    branchType;
    logic [IW-1:0] branchIdx, lutWrAddr;
    logic          lutWrite;
    logic [PW-1:0] lutWrData;
    logic [PW-1:0] pc;
    logic          flagEq, flagLt, taken, running, done;

    typedef struct {
        string         tag;
        logic [PW-1:0] pc;
        logic          eq;
        logic          lt;
        logic          run;
        logic          dn;
    } exp_t;

    exp_t sbQ[$];
    int   total = 0;
    int   bad   = 0;
    logic expEq, expLt, expRun, expDone;

    pc_flag_unit #(.PC_WIDTH(PW), .LUT_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .alu_equal(alu_equal), .alu_lessThan(alu_lessThan), .flagWrite(flagWrite),
        .branchType(branchType), .branchIdx(branchIdx),
        .lutWrite(lutWrite), .lutWrAddr(lutWrAddr), .lutWrData(lutWrData),
        .pc(pc), .flagEq(flagEq), .flagLt(flagLt), .taken(taken),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clearInputs();
        reset = 0; start = 0; stall = 0; halt = 0;
        alu_equal = 0; alu_lessThan = 0; flagWrite = 0;
        branchType = 2'b00; branchIdx = '0;
        lutWrite = 0; lutWrAddr = '0; lutWrData = '0;
    endtask

    task automatic setLut(input logic [IW-1:0] a, input logic [PW-1:0] d);
        lutWrite = 1; lutWrAddr = a; lutWrData = d;
    endtask

    task automatic setBranch(input logic [1:0] t, input logic [IW-1:0] i);
        branchType = t; branchIdx = i;
    endtask

    task automatic setCmp(input logic eq, input logic lt);
        flagWrite = 1; alu_equal = eq; alu_lessThan = lt;
    endtask

    // One cycle: check comb taken, queue the post-edge state, clock, compare.
    task automatic tick(input string tag, input logic expTaken, input logic [PW-1:0] ePc);
        exp_t e;
        #1;
        checkVal({tag, ".taken"}, {31'b0, taken}, {31'b0, expTaken});
        e.tag = tag; e.pc = ePc; e.eq = expEq; e.lt = expLt; e.run = expRun; e.dn = expDone;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        e = sbQ.pop_front();
        checkVal({e.tag, ".pc"},      {22'b0, pc},      {22'b0, e.pc});
        checkVal({e.tag, ".flagEq"},  {31'b0, flagEq},  {31'b0, e.eq});
        checkVal({e.tag, ".flagLt"},  {31'b0, flagLt},  {31'b0, e.lt});
        checkVal({e.tag, ".running"}, {31'b0, running}, {31'b0, e.run});
        checkVal({e.tag, ".done"},    {31'b0, done},    {31'b0, e.dn});
        clearInputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clearInputs();
        reset = 1;
        expEq = 0; expLt = 0; expRun = 0; expDone = 0;
        @(posedge clk);
        #1;

        reset = 1; tick("rst0", 0, 10'h000);
        reset = 1; setLut(4'd7, 10'h055); tick("rst1_lutw", 0, 10'h000);

        start = 1; expRun = 1; tick("start", 0, 10'h000);
        setBranch(2'b11, 4'd7); tick("rstPrioLut", 1, 10'h000);
        tick("seq1", 0, 10'h001);
        setLut(4'd3, 10'h02A); tick("seq2", 0, 10'h002);
        setLut(4'd4, 10'h005); tick("seq3", 0, 10'h003);
        setLut(4'd5, 10'h009); tick("seq4", 0, 10'h004);
        setLut(4'd6, 10'h3FF); tick("seq5", 0, 10'h005);

        setCmp(1, 0); expEq = 1; tick("cmpEq1", 0, 10'h006);
        setBranch(2'b01, 4'd3); tick("beqTaken", 1, 10'h02A);
        setBranch(2'b11, 4'd4); tick("jmpBack", 1, 10'h005);
        setCmp(0, 0); expEq = 0; tick("cmpEq0", 0, 10'h006);
        setBranch(2'b01, 4'd3); tick("beqNot", 0, 10'h007);

        setCmp(0, 1); setBranch(2'b10, 4'd3); expLt = 1; tick("sameCycle", 0, 10'h008);
        setBranch(2'b10, 4'd5); tick("bltTaken", 1, 10'h009);

        halt = 1; setBranch(2'b11, 4'd3); setCmp(1, 1);
        expEq = 1; expLt = 1; expRun = 0; expDone = 1; tick("halt", 0, 10'h009);
        setCmp(0, 0); setBranch(2'b11, 4'd3); tick("doneIgnore", 0, 10'h009);
        start = 1; expRun = 1; expDone = 0; tick("restart", 0, 10'h000);
        start = 1; tick("startInRun", 0, 10'h001);

        setBranch(2'b11, 4'd6); tick("jmpMax", 1, 10'h3FF);
        stall = 1; setBranch(2'b11, 4'd6); setCmp(0, 0); setLut(4'd2, 10'h010);
        tick("stall1", 0, 10'h3FF);
        stall = 1; setBranch(2'b11, 4'd6); setCmp(0, 0); tick("stall2", 0, 10'h3FF);
        stall = 1; setBranch(2'b11, 4'd6); halt = 1; tick("stall3", 0, 10'h3FF);
        tick("wrap", 0, 10'h000);

        setLut(4'd2, 10'h020); setBranch(2'b11, 4'd2); tick("collide", 1, 10'h010);
        setBranch(2'b11, 4'd2); tick("newEntry", 1, 10'h020);

        reset = 1; stall = 1; start = 1; setLut(4'd2, 10'h033); setBranch(2'b11, 4'd2);
        expEq = 0; expLt = 0; expRun = 0; expDone = 0; tick("midReset", 0, 10'h000);
        start = 1; expRun = 1; tick("start2", 0, 10'h000);
        setBranch(2'b11, 4'd2); tick("lut2Cleared", 1, 10'h000);
        setBranch(2'b11, 4'd3); tick("lut3Cleared", 1, 10'h000);
        tick("post", 0, 10'h001);

        checkVal("sbEmpty", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
